retire_rrat: RTL and testbench

//  Retirement register alias table (RRAT) and freelist replenisher at the commit end of the rename pipe.
//  - Tracks the committed arch->phys mapping.
//  - On each retiring register write, returns the superseded physical register to the rename freelist via rrat_free/rrat_free_reg.
//  - After reset and after every FLUSH, walks all physical registers and re-enqueues every one not held by the RRAT.

---
 rtl/retire_rrat_if.sv | 23 ++
 rtl/retire_rrat.sv | 125 ++++++++++++
 tb/tb_retire_rrat.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/retire_rrat_if.sv
// Commit-side bus of the retirement RAT: retiring-instruction inputs, freelist
// enqueue strobe, committed map and rebuild status.
interface retire_rrat_if;
    logic        commit_valid;
    logic        commit_regwr;
    logic [4:0]  commit_arch_reg;
    logic [5:0]  commit_phys_reg;
    logic        rrat_free;
    logic [5:0]  rrat_free_reg;
    logic [5:0]  rrat_my_map [31:0];
    logic        rebuild_busy;
    logic [31:0] retire_count;

    modport master (
        output commit_valid, commit_regwr, commit_arch_reg, commit_phys_reg,
        input  rrat_free, rrat_free_reg, rrat_my_map, rebuild_busy, retire_count
    );

    modport slave (
        input  commit_valid, commit_regwr, commit_arch_reg, commit_phys_reg,
        output rrat_free, rrat_free_reg, rrat_my_map, rebuild_busy, retire_count
    );
endinterface

// File: rtl/retire_rrat.sv
// Retirement register alias table: holds the committed arch->phys map, returns
// superseded physical registers to the freelist and rebuilds the freelist after reset/flush.
module retire_rrat (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         STALL,
    input  logic         FLUSH,
    retire_rrat_if.slave rif
);
    localparam int NUM_ARCH = 32;
    localparam int NUM_PHYS = 64;

    typedef enum logic [0:0] {
        ST_REBUILD = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t      state_r;
    logic [5:0]  map_r [31:0];
    logic [5:0]  idx_r;
    logic        free_r;
    logic [5:0]  free_reg_r;
    logic        busy_r;
    logic [31:0] count_r;

    logic        idx_mapped_s;
    logic [5:0]  old_phys_s;
    logic        commit_free_s;
    logic [5:0]  commit_free_reg_s;

    // Walk test: is the current walk index held by any committed mapping
    always_comb begin
        idx_mapped_s = 1'b0;
        for (int i = 0; i < NUM_ARCH; i++) begin
            idx_mapped_s = idx_mapped_s | (map_r[i] == idx_r);
        end
    end

    // Register to release on a retiring write; r0 writes free their own phys reg
    always_comb begin
        old_phys_s        = map_r[rif.commit_arch_reg];
        commit_free_s     = 1'b0;
        commit_free_reg_s = 6'd0;
        if (rif.commit_regwr) begin
            if (rif.commit_arch_reg != 5'd0) begin
                commit_free_s     = (old_phys_s != 6'd0) && (old_phys_s != rif.commit_phys_reg);
                commit_free_reg_s = old_phys_s;
            end else begin
                commit_free_s     = (rif.commit_phys_reg != 6'd0);
                commit_free_reg_s = rif.commit_phys_reg;
            end
        end else begin
            commit_free_s     = 1'b0;
            commit_free_reg_s = 6'd0;
        end
    end

    // Map, walk FSM, free strobe and retire counter
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_r[i] <= 6'(i);
            end
            state_r    <= ST_REBUILD;
            idx_r      <= 6'd1;
            free_r     <= 1'b0;
            free_reg_r <= 6'd0;
            busy_r     <= 1'b1;
            count_r    <= 32'd0;
        end else if (STALL) begin
            free_r <= 1'b0;
        end else begin
            case (state_r)
                ST_REBUILD: begin
                    if (FLUSH) begin
                        idx_r  <= 6'd1;
                        free_r <= 1'b0;
                    end else begin
                        free_r <= ~idx_mapped_s;
                        if (!idx_mapped_s) begin
                            free_reg_r <= idx_r;
                        end
                        idx_r <= idx_r + 6'd1;
                        if (idx_r == 6'(NUM_PHYS - 1)) begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    free_r <= 1'b0;
                    if (rif.commit_valid) begin
                        count_r <= count_r + 32'd1;
                        if (rif.commit_regwr && (rif.commit_arch_reg != 5'd0)) begin
                            map_r[rif.commit_arch_reg] <= rif.commit_phys_reg;
                        end
                        if (commit_free_s) begin
                            free_r     <= 1'b1;
                            free_reg_r <= commit_free_reg_s;
                        end
                    end
                    // A flushed commit's old reg is unmapped now, so the walk re-enqueues it
                    if (FLUSH) begin
                        state_r <= ST_REBUILD;
                        idx_r   <= 6'd1;
                        busy_r  <= 1'b1;
                        free_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_REBUILD;
                    idx_r   <= 6'd1;
                    busy_r  <= 1'b1;
                    free_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rif.rrat_free     = free_r;
    assign rif.rrat_free_reg = free_reg_r;
    assign rif.rrat_my_map   = map_r;
    assign rif.rebuild_busy  = busy_r;
    assign rif.retire_count  = count_r;
endmodule

// File: tb/tb_retire_rrat.sv
// Bench for retire_rrat: expected freelist enqueues go into a queue as stimulus
// is driven and are popped whenever the DUT strobes rrat_free.
module tb_retire_rrat;
    logic CLK;
    logic RESET;
    logic STALL;
    logic FLUSH;

    retire_rrat_if rif ();

    retire_rrat dut (
        .CLK   (CLK),
        .RESET (RESET),
        .STALL (STALL),
        .FLUSH (FLUSH),
        .rif   (rif)
    );

    typedef struct {
        logic       v;
        logic       w;
        logic [4:0] a;
        logic [5:0] p;
        int         ecnt;
        logic [5:0] emap;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   exp_q [$];
    vec_t tbl [11];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard: every free strobe must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (RESET === 1'b1 && rif.rrat_free === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_free got reg %0d expected no free", rif.rrat_free_reg);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(rif.rrat_free_reg) != e) begin
                    failures++;
                    $display("FAIL free_reg got %0d expected %0d", rif.rrat_free_reg, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic push_range(input int ex0, input int ex1);
        for (int r = 32; r < 64; r++) begin
            if (r != ex0 && r != ex1) exp_q.push_back(r);
        end
    endtask

    task automatic walk(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (rif.rebuild_busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(name, n, exp_cycles);
        @(negedge CLK);
        #1;
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_identity(input string name);
        for (int i = 0; i < 32; i++) check(name, int'(rif.rrat_my_map[i]), i);
    endtask

    task automatic commit(input logic v, input logic w, input logic [4:0] a, input logic [5:0] p);
        rif.commit_valid    = v;
        rif.commit_regwr    = w;
        rif.commit_arch_reg = a;
        rif.commit_phys_reg = p;
    endtask

    initial begin
        RESET = 1'b0;
        STALL = 1'b0;
        FLUSH = 1'b0;
        commit(1'b0, 1'b0, 5'd0, 6'd0);

        // v  w  arch phys  count  map[arch]
        tbl[0]  = '{1'b1, 1'b1, 5'd5, 6'd40, 1,  6'd40};
        tbl[1]  = '{1'b1, 1'b1, 5'd0, 6'd33, 2,  6'd0};
        tbl[2]  = '{1'b1, 1'b0, 5'd7, 6'd50, 3,  6'd7};
        tbl[3]  = '{1'b0, 1'b1, 5'd6, 6'd41, 3,  6'd6};
        tbl[4]  = '{1'b1, 1'b1, 5'd9, 6'd9,  4,  6'd9};
        tbl[5]  = '{1'b1, 1'b1, 5'd9, 6'd0,  5,  6'd0};
        tbl[6]  = '{1'b1, 1'b1, 5'd9, 6'd0,  6,  6'd0};
        tbl[7]  = '{1'b1, 1'b1, 5'd9, 6'd9,  7,  6'd9};
        tbl[8]  = '{1'b1, 1'b1, 5'd3, 6'd50, 8,  6'd50};
        tbl[9]  = '{1'b1, 1'b1, 5'd7, 6'd33, 9,  6'd33};
        tbl[10] = '{1'b1, 1'b1, 5'd5, 6'd5,  10, 6'd5};

        // Reset state and initial freelist build
        repeat (3) tick();
        check("rst_free", int'(rif.rrat_free), 0);
        check("rst_free_reg", int'(rif.rrat_free_reg), 0);
        check("rst_busy", int'(rif.rebuild_busy), 1);
        check("rst_count", int'(rif.retire_count), 0);
        check_identity("rst_map");
        push_range(-1, -1);
        RESET = 1'b1;
        walk("p1_walk_cycles", 63);
        check_identity("p1_map");

        // Retiring writes in RUN; frees expected from the superseded mapping
        exp_q.push_back(5);
        exp_q.push_back(33);
        exp_q.push_back(9);
        exp_q.push_back(3);
        exp_q.push_back(7);
        exp_q.push_back(40);
        for (int k = 0; k < 11; k++) begin
            commit(tbl[k].v, tbl[k].w, tbl[k].a, tbl[k].p);
            tick();
            check($sformatf("vec%0d_count", k), int'(rif.retire_count), tbl[k].ecnt);
            check($sformatf("vec%0d_map", k), int'(rif.rrat_my_map[tbl[k].a]), int'(tbl[k].emap));
        end
        commit(1'b0, 1'b0, 5'd0, 6'd0);
        tick();
        check("p2_pending", exp_q.size(), 0);

        // Flush with map[3]=50, map[7]=33; a commit during the walk is ignored
        exp_q.push_back(3);
        exp_q.push_back(7);
        push_range(33, 50);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("p4_busy", int'(rif.rebuild_busy), 1);
        check("p4_free_at_flush", int'(rif.rrat_free), 0);
        commit(1'b1, 1'b1, 5'd10, 6'd60);
        tick();
        commit(1'b0, 1'b0, 5'd0, 6'd0);
        walk("p4_walk_cycles", 62);
        check("p4_count", int'(rif.retire_count), 10);
        check("p4_map10", int'(rif.rrat_my_map[10]), 10);
        check("p4_map3", int'(rif.rrat_my_map[3]), 50);

        // Stall for 4 cycles with idx at 40; walk resumes there
        exp_q.push_back(3);
        exp_q.push_back(7);
        push_range(33, 50);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (39) tick();
        STALL = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            check("p5_stall_free", int'(rif.rrat_free), 0);
            check("p5_stall_busy", int'(rif.rebuild_busy), 1);
        end
        STALL = 1'b0;
        walk("p5_resume_cycles", 24);

        // Reset in the middle of a walk reinitialises everything
        exp_q.push_back(3);
        exp_q.push_back(7);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (20) tick();
        check("p5_pre_reset_pending", exp_q.size(), 0);
        RESET = 1'b0;
        #1;
        check("p5_reset_busy", int'(rif.rebuild_busy), 1);
        check("p5_reset_count", int'(rif.retire_count), 0);
        check("p5_reset_free", int'(rif.rrat_free), 0);
        check_identity("p5_reset_map");
        tick();
        push_range(-1, -1);
        RESET = 1'b1;
        walk("p5_rewalk_cycles", 63);

        // Flush together with a commit: map updated, its free deferred to the walk
        exp_q.push_back(4);
        push_range(45, -1);
        commit(1'b1, 1'b1, 5'd4, 6'd45);
        FLUSH = 1'b1;
        tick();
        commit(1'b0, 1'b0, 5'd0, 6'd0);
        FLUSH = 1'b0;
        check("p6_free_at_flush", int'(rif.rrat_free), 0);
        check("p6_map4", int'(rif.rrat_my_map[4]), 45);
        check("p6_count", int'(rif.retire_count), 1);
        walk("p6_walk_cycles", 63);

        // Stalled commit in RUN is not accepted
        STALL = 1'b1;
        commit(1'b1, 1'b1, 5'd5, 6'd20);
        tick();
        commit(1'b0, 1'b0, 5'd0, 6'd0);
        STALL = 1'b0;
        check("p7_stall_count", int'(rif.retire_count), 1);
        check("p7_stall_map5", int'(rif.rrat_my_map[5]), 5);
        tick();
        check("p7_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
